// File: rtl/rle_bitmap_writer_pkg.sv
// Shared definitions for the RLE bitmap writer and the display-side reader.
// Both sides must agree on the bitmap geometry and on how a run length is decoded.
package rle_bitmap_writer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGetLen,
        StGetVal,
        StWrite,
        StDone
    } state_e;

    localparam int unsigned RLE_LEN_ZERO   = 256;
    localparam int unsigned RUN_W          = 9;
    localparam int unsigned DEFAULT_WIDTH  = 72;
    localparam int unsigned DEFAULT_HEIGHT = 512;
    localparam int unsigned DEFAULT_ADDR_W = 16;

    // A LEN byte of zero encodes the longest run, so one record can cover 256 pixels.
    function automatic logic [RUN_W-1:0] decode_len(input logic [7:0] len_byte);
        if (len_byte == 8'd0) begin
            return RUN_W'(RLE_LEN_ZERO);
        end
        return {1'b0, len_byte};
    endfunction

endpackage

// File: rtl/rle_bitmap_writer_pix_cnt.sv
// Pixel address counter: cleared at frame start, advanced once per issued write,
// with a flag marking the final pixel of the frame.
module rle_bitmap_writer_pix_cnt
    import rle_bitmap_writer_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned LAST   = DEFAULT_WIDTH * DEFAULT_HEIGHT - 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_count,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + ADDR_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == ADDR_W'(LAST));

endmodule

// File: rtl/rle_bitmap_writer.sv
// Decodes a two-byte-per-record RLE stream into sequential 8-bit pixel writes
// into the image RAM, row-major from address 0.
module rle_bitmap_writer
    import rle_bitmap_writer_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned HEIGHT = DEFAULT_HEIGHT,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              i_pixel_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [7:0]        i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    localparam int unsigned       LAST     = WIDTH * HEIGHT - 1;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(LAST);

    state_e            r_state;
    logic [RUN_W-1:0]  r_run;
    logic              r_in_ready;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic              w_xfer;
    logic              w_issue;
    logic [ADDR_W-1:0] w_pix;
    logic              w_pix_last;

    assign w_xfer = i_in_valid && r_in_ready;

    // r_run counts writes of the current record not yet issued; a write is issued
    // on the VAL transfer and then once per cycle while the run and frame last.
    always_comb begin
        w_issue = 1'b0;
        if (!i_start) begin
            case (r_state)
                StGetVal: w_issue = w_xfer;
                StWrite:  w_issue = (r_wr_addr != LAST_PIX) && (r_run != '0);
                default:  w_issue = 1'b0;
            endcase
        end
    end

    rle_bitmap_writer_pix_cnt #(
        .ADDR_W (ADDR_W),
        .LAST   (LAST)
    ) u_pix_cnt (
        .i_clk   (i_pixel_clk),
        .i_reset (i_reset),
        .i_clear (i_start),
        .i_inc   (w_issue),
        .o_count (w_pix),
        .o_last  (w_pix_last)
    );

    always_ff @(posedge i_pixel_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_run      <= '0;
            r_in_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else if (i_start) begin
            // Restart wins over everything; the old run is dropped mid-flight.
            r_state    <= StGetLen;
            r_run      <= '0;
            r_in_ready <= 1'b1;
            r_wr_en    <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;

            if (w_issue) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= w_pix;
                r_run     <= r_run - RUN_W'(1);
                // Final pixel reached with run left over: flag it with this write.
                if (w_pix_last && (r_run != RUN_W'(1))) begin
                    r_error <= 1'b1;
                end
            end

            case (r_state)
                StIdle: begin
                    r_in_ready <= 1'b0;
                end
                StGetLen: begin
                    if (w_xfer) begin
                        r_run   <= decode_len(i_in_data);
                        r_state <= StGetVal;
                    end
                end
                StGetVal: begin
                    if (w_xfer) begin
                        r_wr_data  <= i_in_data;
                        r_in_ready <= 1'b0;
                        r_state    <= StWrite;
                    end
                end
                StWrite: begin
                    if (r_wr_addr == LAST_PIX) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= StDone;
                    end else if (r_run == '0) begin
                        r_in_ready <= 1'b1;
                        r_state    <= StGetLen;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= StIdle;
                end
            endcase
        end
    end

    assign o_in_ready = r_in_ready;
    assign o_wr_en    = r_wr_en;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_error    = r_error;

endmodule

// File: doc/rle_bitmap_writer.md
Name: rle_bitmap_writer

Overview:
- Fills the sprite/bitmap RAM that the display path reads, instead of reading it for display.
- Accepts a run-length-encoded byte stream over a valid/ready handshake. Typical sources are a host loader or a flash copier.
- Decodes the stream into consecutive 8-bit pixel writes at addresses 0..WIDTH*HEIGHT-1, row-major (addr = col + row*WIDTH).
- Sits between the stream source and the write port of the dual-port image RAM.

Parameters:
- WIDTH, 72, bitmap width in pixels.
- HEIGHT, 512, bitmap height in pixels.
- ADDR_W, 16, write address width; WIDTH*HEIGHT must be <= 2^ADDR_W.

Ports:
- pixel_clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle pulse; begins (or restarts) a frame load at address 0.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle; a transfer occurs when in_valid && in_ready.
- wr_en  output  1  RAM write strobe.
- wr_addr  output  ADDR_W  RAM write address.
- wr_data  output  8  RAM write data.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse when the last pixel write has been issued.
- error  output  1  sticky overrun flag; cleared by start or reset.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - All outputs 0, state IDLE.
  - Pixel counter, run counter and error cleared.
- Stream format: a sequence of records, each two bytes.
  - LEN byte: run length 1..255; 0x00 means 256.
  - VAL byte: pixel value.
- States and transitions:
  - IDLE: in_ready=0, busy=0. On start: pixel counter=0, error=0, go to GET_LEN.
  - GET_LEN: in_ready=1. On a transfer: latch the run (0 -> 256), go to GET_VAL.
  - GET_VAL: in_ready=1. On a transfer: latch the value, go to WRITE.
  - WRITE: in_ready=0. One write per cycle: wr_en=1, wr_addr=pixel counter, wr_data=value. Pixel counter and run counter advance together.
    - Run exhausted and frame not complete -> GET_LEN.
    - Pixel WIDTH*HEIGHT-1 written -> DONE.
  - DONE: done=1 for exactly one cycle, busy drops, then IDLE.
- Outputs are registered.
  - The VAL transfer in cycle N gives the first wr_en in cycle N+1.
  - A run of L gives L consecutive wr_en cycles with addresses incrementing by 1.
  - wr_en is 0 outside WRITE; wr_addr/wr_data hold their last values.
- Overrun: if a run would extend past pixel WIDTH*HEIGHT-1:
  - Writes stop at the last pixel and no out-of-range address is ever driven.
  - error is set in the cycle of the final write; done still pulses.
  - Any remaining stream bytes are not accepted (in_ready=0 in IDLE).
- Frame ending between records: the last run ends exactly on the final pixel. No further LEN is requested; go directly to DONE.
- start while busy:
  - Aborts the current load; the next cycle is GET_LEN with pixel counter 0 and error cleared.
  - A write in progress in the start cycle completes; no further writes from the old run.
  - No done pulse for the aborted frame.
- start with in_valid high in the same cycle: that byte is not consumed, because in_ready is evaluated from the current state.
- in_valid low in GET_LEN/GET_VAL: wait indefinitely; no timeout.
- Width rules:
  - Pixel counter is ADDR_W bits and compares against the constant WIDTH*HEIGHT-1.
  - Run counter is 9 bits to hold 256.

Decomposition:
- Shared header (rle_defs.vh):
  - State encodings IDLE/GET_LEN/GET_VAL/WRITE/DONE.
  - RLE_LEN_ZERO=256.
  - Default WIDTH/HEIGHT, shared with the display-side reader so both agree on addressing.
- No sub-module required. The FSM plus two counters fit in one module.
- Optional: a pixel_addr_counter sub-module (load-zero, increment, terminal-count flag).

Test Plan:
- Reset mid-run: after start, send LEN=10/VAL=0x55 and assert reset on the 4th write -> the next cycle shows wr_en=0, busy=0, in_ready=0; a subsequent start resumes from addr 0.
- Single-run fill: WIDTH=4, HEIGHT=2, start, LEN=8, VAL=0xAB -> wr_en high for 8 cycles, addr 0..7, data 0xAB, first write one cycle after the VAL transfer, then done=1 for one cycle, error=0.
- Mixed runs with stalls: WIDTH=4, HEIGHT=2, records (3,0x11),(5,0x22), in_valid toggled every other cycle -> addr 0-2 get 0x11, addr 3-7 get 0x22, no writes during stalls, single done.
- LEN=0 semantic: WIDTH=16, HEIGHT=16, records (0,0xFF) -> 256 writes, addr 0..255, done, error=0.
- Overrun: WIDTH=4, HEIGHT=2, records (6,0x01),(5,0x02) -> addr 6,7 get 0x02, no addr 8, error=1 sticky, done pulses; error stays set until the next start clears it.
- Restart: start, (3,0x10), then start pulsed during the 2nd write, then (2,0x20) -> one further write of 0x10 at most (the one issued in the start cycle), then writes of 0x20 at addr 0 and 1, no done for the aborted frame.
